// File: rtl/alu_mul_seq.sv
// Shift-add sequential multiplier that borrows the shared execute-stage ALU for its adds.
// Optional build macro MUL_SIGNED_EN adds the isigned port and signed-operand handling.
`ifndef ADD_OP
`define ADD_OP 4'h1
`endif

module alu_mul_seq #(
  parameter int MP_DATA_WIDTH = 32
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     istart,
  input  logic                     iflush,
  input  logic [MP_DATA_WIDTH-1:0] isrc_a,
  input  logic [MP_DATA_WIDTH-1:0] isrc_b,
`ifdef MUL_SIGNED_EN
  input  logic                     isigned,
`endif
  input  logic                     igrant,
  input  logic [MP_DATA_WIDTH-1:0] ialu_result,
  input  logic                     ialu_carry,
  output logic                     oalu_req,
  output logic [3:0]               oalu_ctrl,
  output logic [MP_DATA_WIDTH-1:0] oalu_src_a,
  output logic [MP_DATA_WIDTH-1:0] oalu_src_b,
  output logic                     obusy,
  output logic                     odone,
  output logic [MP_DATA_WIDTH-1:0] oprod_hi,
  output logic [MP_DATA_WIDTH-1:0] oprod_lo
);
  localparam int W  = MP_DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  mcand, acc_hi, acc_lo;
  logic [CW-1:0] count;
  logic [W:0]    t;
  logic [2*W-1:0] prod_nxt, prod_fin;
  logic          start_ok, step, last_step;
  logic [W-1:0]  cap_a, cap_b;
`ifdef MUL_SIGNED_EN
  logic          neg;
`endif

  assign start_ok  = (state == S_IDLE) && istart && !iflush;
  assign step      = (state == S_RUN) && igrant && !iflush;
  assign last_step = step && (count == LAST);

  // Carry from the ALU becomes bit W of the partial sum, so no bit is ever lost.
  assign t        = acc_lo[0] ? {ialu_carry, ialu_result} : {1'b0, acc_hi};
  assign prod_nxt = {t, acc_lo[W-1:1]};

`ifdef MUL_SIGNED_EN
  assign cap_a    = (isigned && isrc_a[W-1]) ? -isrc_a : isrc_a;
  assign cap_b    = (isigned && isrc_b[W-1]) ? -isrc_b : isrc_b;
  assign prod_fin = neg ? -prod_nxt : prod_nxt;
`else
  assign cap_a    = isrc_a;
  assign cap_b    = isrc_b;
  assign prod_fin = prod_nxt;
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    oalu_req   = 1'b0;
    oalu_ctrl  = 4'h0;
    oalu_src_a = '0;
    oalu_src_b = '0;
    obusy      = 1'b0;
    odone      = 1'b0;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_RUN;
      S_RUN: begin
        oalu_req   = 1'b1;
        oalu_ctrl  = `ADD_OP;
        oalu_src_a = acc_hi;
        oalu_src_b = mcand;
        obusy      = 1'b1;
        if (iflush)         state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        obusy     = 1'b1;
        odone     = !iflush;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      count    <= '0;
      oprod_hi <= '0;
      oprod_lo <= '0;
`ifdef MUL_SIGNED_EN
      neg      <= 1'b0;
`endif
    end else if (start_ok) begin
      mcand  <= cap_a;
      acc_hi <= '0;
      acc_lo <= cap_b;
      count  <= '0;
`ifdef MUL_SIGNED_EN
      neg    <= isigned && (isrc_a[W-1] ^ isrc_b[W-1]);
`endif
    end else if (step) begin
      {acc_hi, acc_lo} <= prod_nxt;
      count            <= count + CW'(1);
      if (last_step) {oprod_hi, oprod_lo} <= prod_fin;
    end
  end
endmodule
